// File: rtl/lsu_mem_port.sv
// Load/store unit bus port: one outstanding access, stalls the pipeline
// until the bus completes, aligns/extends load data, aborts on timeout.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ex_mem_read/_write  EX-stage load/store request (both set = load)
//   ex_mem_data_mask    size 00 byte, 01 half, 10 word, 11 illegal
//   ex_funct3           bit 2 selects zero-extended load
//   ex_addr, ex_wdata   effective byte address, store data
//   bus_req/we/addr/be/wdata  request side of the memory bus
//   bus_gnt, bus_rvalid, bus_rdata  bus responses
//   lsu_stall           freeze IF/ID/EX registers
//   lsu_rdata(_valid)   aligned load result and its one-cycle pulse
//   lsu_misaligned      misaligned/illegal access (combinational, IDLE)
//   lsu_bus_err         timeout abort pulse
module lsu_mem_port #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [1:0]  ex_mem_data_mask,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        lsu_stall,
    output logic [31:0] lsu_rdata,
    output logic        lsu_rdata_valid,
    output logic        lsu_misaligned,
    output logic        lsu_bus_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic [31:0] r_addr;
    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_op;
    logic        w_mis;
    logic        w_go;
    logic        w_we;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_tmo;
    logic        w_abort;
    logic [31:0] w_sh;
    logic [31:0] w_ext;
    logic        w_unused;

    assign w_unused = &{1'b0, ex_funct3[1:0]};

    assign w_op  = ex_mem_read | ex_mem_write;
    assign w_we  = ex_mem_write & ~ex_mem_read;
    assign w_mis = ((ex_mem_data_mask == 2'b01) & ex_addr[0])
                 | ((ex_mem_data_mask == 2'b10) & (ex_addr[1:0] != 2'b00))
                 |  (ex_mem_data_mask == 2'b11);
    assign w_go  = (r_state == S_IDLE) & w_op & ~w_mis;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = ex_wdata;
        case (ex_mem_data_mask)
            2'b00: begin
                w_be    = 4'b0001 << ex_addr[1:0];
                w_wdata = {4{ex_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << ex_addr[1:0];
                w_wdata = {2{ex_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = ex_wdata;
            end
        endcase
    end

    // Last allowed cycle in REQ+WAIT; a completing gnt/rvalid still wins.
    assign w_tmo   = (r_cnt == 8'(TIMEOUT - 1));
    assign w_abort = w_tmo
                   & (((r_state == S_REQ) & ~bus_gnt)
                   |  ((r_state == S_WAIT) & ~bus_rvalid));

    assign w_sh = bus_rdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_ext = w_sh;
        case (r_size)
            2'b00:   w_ext = {{24{~r_uns & w_sh[7]}}, w_sh[7:0]};
            2'b01:   w_ext = {{16{~r_uns & w_sh[15]}}, w_sh[15:0]};
            default: w_ext = w_sh;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_go) w_next = S_REQ;
            end
            S_REQ: begin
                if (bus_gnt)    w_next = r_we ? S_DONE : S_WAIT;
                else if (w_tmo) w_next = S_DONE;
            end
            S_WAIT: begin
                if (bus_rvalid || w_tmo) w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_addr  <= 32'd0;
            r_we    <= 1'b0;
            r_be    <= 4'd0;
            r_wdata <= 32'd0;
            r_size  <= 2'd0;
            r_uns   <= 1'b0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_go) begin
                r_cnt   <= 8'd0;
                r_addr  <= ex_addr;
                r_we    <= w_we;
                r_be    <= w_be;
                r_wdata <= w_wdata;
                r_size  <= ex_mem_data_mask;
                r_uns   <= ex_funct3[2];
                r_err   <= 1'b0;
            end
            if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if ((r_state == S_WAIT) && bus_rvalid) begin
                r_rdata <= w_ext;
            end
            if (w_abort) begin
                r_err   <= 1'b1;
                r_rdata <= 32'd0;
            end
        end
    end

    // Bus fields are only presented while requesting so the bus sees
    // zeros whenever the port is idle.
    assign bus_req   = (r_state == S_REQ);
    assign bus_we    = bus_req & r_we;
    assign bus_addr  = bus_req ? {r_addr[31:2], 2'b00} : 32'd0;
    assign bus_be    = bus_req ? r_be : 4'd0;
    assign bus_wdata = bus_req ? r_wdata : 32'd0;

    assign lsu_stall = w_go
                     | (r_state == S_REQ)
                     | (r_state == S_WAIT);
    assign lsu_misaligned  = (r_state == S_IDLE) & w_op & w_mis;
    assign lsu_rdata       = r_rdata;
    assign lsu_rdata_valid = (r_state == S_DONE) & ~r_we & ~r_err;
    assign lsu_bus_err     = (r_state == S_DONE) & r_err;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port (TIMEOUT=8).
// Inputs change on negedge; outputs are checked 1 time unit later.
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [1:0]  ex_mem_data_mask;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        lsu_stall;
    logic [31:0] lsu_rdata;
    logic        lsu_rdata_valid;
    logic        lsu_misaligned;
    logic        lsu_bus_err;

    int n_chk = 0;
    int n_err = 0;

    lsu_mem_port #(.TIMEOUT(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .ex_mem_read      (ex_mem_read),
        .ex_mem_write     (ex_mem_write),
        .ex_mem_data_mask (ex_mem_data_mask),
        .ex_funct3        (ex_funct3),
        .ex_addr          (ex_addr),
        .ex_wdata         (ex_wdata),
        .bus_req          (bus_req),
        .bus_we           (bus_we),
        .bus_addr         (bus_addr),
        .bus_be           (bus_be),
        .bus_wdata        (bus_wdata),
        .bus_gnt          (bus_gnt),
        .bus_rvalid       (bus_rvalid),
        .bus_rdata        (bus_rdata),
        .lsu_stall        (lsu_stall),
        .lsu_rdata        (lsu_rdata),
        .lsu_rdata_valid  (lsu_rdata_valid),
        .lsu_misaligned   (lsu_misaligned),
        .lsu_bus_err      (lsu_bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clr_ex();
        ex_mem_read      = 1'b0;
        ex_mem_write     = 1'b0;
        ex_mem_data_mask = 2'b00;
        ex_funct3        = 3'b000;
        ex_addr          = 32'd0;
        ex_wdata         = 32'd0;
    endtask

    task automatic issue(input logic rd, input logic [1:0] m,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        nxt();
        ex_mem_read      = rd;
        ex_mem_write     = ~rd;
        ex_mem_data_mask = m;
        ex_funct3        = f3;
        ex_addr          = a;
        ex_wdata         = wd;
        settle();
    endtask

    // Load with immediate grant and data on the first WAIT cycle.
    task automatic quick_load(input string tag, input logic [1:0] m,
                              input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] rd, input logic [3:0] ebe,
                              input logic [31:0] ev);
        issue(1'b1, m, f3, a, 32'd0);
        chk({tag, "_stall0"}, 32'(lsu_stall), 32'd1);
        nxt();
        clr_ex();
        bus_gnt = 1'b1;
        settle();
        chk({tag, "_req"}, 32'(bus_req), 32'd1);
        chk({tag, "_be"}, 32'(bus_be), 32'(ebe));
        chk({tag, "_addr"}, bus_addr, {a[31:2], 2'b00});
        nxt();
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = rd;
        settle();
        nxt();
        bus_rvalid = 1'b0;
        settle();
        chk({tag, "_valid"}, 32'(lsu_rdata_valid), 32'd1);
        chk({tag, "_rdata"}, lsu_rdata, ev);
        chk({tag, "_stall_done"}, 32'(lsu_stall), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = 32'd0;
        clr_ex();
        nxt();
        nxt();
        settle();
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_be", 32'(bus_be), 32'd0);
        chk("rst_stall", 32'(lsu_stall), 32'd0);
        chk("rst_rdata", lsu_rdata, 32'd0);
        chk("rst_err", 32'(lsu_bus_err), 32'd0);
        rst = 1'b0;

        // LB 0x1003, gnt in first REQ cycle, rvalid on second WAIT cycle
        issue(1'b1, 2'b00, 3'b000, 32'h1003, 32'd0);
        chk("lb_stall_idle", 32'(lsu_stall), 32'd1);
        chk("lb_req_idle", 32'(bus_req), 32'd0);
        nxt();
        clr_ex();
        bus_gnt = 1'b1;
        settle();
        chk("lb_req", 32'(bus_req), 32'd1);
        chk("lb_be", 32'(bus_be), 32'h8);
        chk("lb_addr", bus_addr, 32'h1000);
        chk("lb_we", 32'(bus_we), 32'd0);
        nxt();
        bus_gnt = 1'b0;
        settle();
        chk("lb_wait_req", 32'(bus_req), 32'd0);
        chk("lb_wait_stall", 32'(lsu_stall), 32'd1);
        nxt();
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h80FF_FF00;
        settle();
        chk("lb_wait_novalid", 32'(lsu_rdata_valid), 32'd0);
        nxt();
        bus_rvalid = 1'b0;
        settle();
        chk("lb_valid", 32'(lsu_rdata_valid), 32'd1);
        chk("lb_rdata", lsu_rdata, 32'hFFFF_FF80);
        chk("lb_stall_done", 32'(lsu_stall), 32'd0);
        nxt();
        settle();
        chk("lb_valid_once", 32'(lsu_rdata_valid), 32'd0);
        chk("lb_rdata_hold", lsu_rdata, 32'hFFFF_FF80);

        quick_load("lhu", 2'b01, 3'b101, 32'h2002, 32'hBEEF_1234,
                   4'b1100, 32'h0000_BEEF);
        quick_load("lh", 2'b01, 3'b001, 32'h0000, 32'h0000_8001,
                   4'b0011, 32'hFFFF_8001);
        quick_load("lbu", 2'b00, 3'b100, 32'h0041, 32'h0000_9C00,
                   4'b0010, 32'h0000_009C);
        quick_load("lw", 2'b10, 3'b010, 32'h0004, 32'h1234_5678,
                   4'b1111, 32'h1234_5678);

        // SB 0x10, gnt on third REQ cycle
        issue(1'b0, 2'b00, 3'b000, 32'h10, 32'h0000_00AB);
        chk("sb_stall1", 32'(lsu_stall), 32'd1);
        nxt();
        clr_ex();
        settle();
        chk("sb_wdata", bus_wdata, 32'hABAB_ABAB);
        chk("sb_be", 32'(bus_be), 32'h1);
        chk("sb_we", 32'(bus_we), 32'd1);
        chk("sb_stall2", 32'(lsu_stall), 32'd1);
        nxt();
        settle();
        chk("sb_hold_wdata", bus_wdata, 32'hABAB_ABAB);
        chk("sb_stall3", 32'(lsu_stall), 32'd1);
        nxt();
        bus_gnt = 1'b1;
        settle();
        chk("sb_stall4", 32'(lsu_stall), 32'd1);
        nxt();
        bus_gnt = 1'b0;
        settle();
        chk("sb_done_stall", 32'(lsu_stall), 32'd0);
        chk("sb_done_novalid", 32'(lsu_rdata_valid), 32'd0);
        chk("sb_done_req", 32'(bus_req), 32'd0);
        chk("sb_rdata_hold", lsu_rdata, 32'h1234_5678);

        // SH 0x2, half replication
        issue(1'b0, 2'b01, 3'b001, 32'h2, 32'h1234_CDEF);
        nxt();
        clr_ex();
        bus_gnt = 1'b1;
        settle();
        chk("sh_wdata", bus_wdata, 32'hCDEF_CDEF);
        chk("sh_be", 32'(bus_be), 32'hC);
        nxt();
        bus_gnt = 1'b0;
        settle();

        // LW 0x06 misaligned
        issue(1'b1, 2'b10, 3'b010, 32'h06, 32'd0);
        chk("mis_flag", 32'(lsu_misaligned), 32'd1);
        chk("mis_stall", 32'(lsu_stall), 32'd0);
        chk("mis_req", 32'(bus_req), 32'd0);
        nxt();
        clr_ex();
        settle();
        chk("mis_req_next", 32'(bus_req), 32'd0);
        chk("mis_clear", 32'(lsu_misaligned), 32'd0);
        issue(1'b1, 2'b11, 3'b000, 32'h00, 32'd0);
        chk("ill_flag", 32'(lsu_misaligned), 32'd1);
        nxt();
        clr_ex();
        settle();

        // LW timeout: 1 REQ + 7 WAIT cycles, then DONE with error
        issue(1'b1, 2'b10, 3'b010, 32'h100, 32'd0);
        nxt();
        clr_ex();
        bus_gnt = 1'b1;
        settle();
        nxt();
        bus_gnt = 1'b0;
        settle();
        for (int i = 0; i < 6; i++) begin
            nxt();
            settle();
        end
        chk("to_stall_last", 32'(lsu_stall), 32'd1);
        chk("to_err_early", 32'(lsu_bus_err), 32'd0);
        nxt();
        settle();
        chk("to_err", 32'(lsu_bus_err), 32'd1);
        chk("to_rdata", lsu_rdata, 32'd0);
        chk("to_novalid", 32'(lsu_rdata_valid), 32'd0);
        chk("to_stall", 32'(lsu_stall), 32'd0);
        nxt();
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hDEAD_BEEF;
        settle();
        chk("to_err_pulse", 32'(lsu_bus_err), 32'd0);
        nxt();
        bus_rvalid = 1'b0;
        settle();
        chk("to_late_valid", 32'(lsu_rdata_valid), 32'd0);
        chk("to_late_rdata", lsu_rdata, 32'd0);

        // Reset while in WAIT
        issue(1'b1, 2'b10, 3'b010, 32'h200, 32'd0);
        nxt();
        clr_ex();
        bus_gnt = 1'b1;
        settle();
        nxt();
        bus_gnt = 1'b0;
        rst     = 1'b1;
        settle();
        chk("rw_stall_wait", 32'(lsu_stall), 32'd1);
        nxt();
        rst = 1'b0;
        settle();
        chk("rw_stall", 32'(lsu_stall), 32'd0);
        chk("rw_req", 32'(bus_req), 32'd0);
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h5555_AAAA;
        nxt();
        bus_rvalid = 1'b0;
        settle();
        chk("rw_novalid", 32'(lsu_rdata_valid), 32'd0);
        chk("rw_rdata", lsu_rdata, 32'd0);
        nxt();
        settle();
        chk("rw_novalid2", 32'(lsu_rdata_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
